pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 96 +++++++++
 tb/tb_pipe_stage_reg.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with optional skid entry.
// Registered head (out_data comes straight from a flop), strict FIFO order,
// synchronous flush that clears held entries, asynchronous active-low reset.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_EMPTY | nothing held, out_valid low
// ST_ONE   | head entry valid in main
// ST_TWO   | head in main, next entry in skid, upstream stalled (SKID=1)
module pipe_stage_reg #(
  parameter int                DATA_W  = 64,
  parameter bit                SKID    = 1'b1,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]        state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              in_fire;
  logic              out_fire;

  // Upstream handshake: the skid variant decouples in_ready from out_ready
  // so the ready chain is cut at this stage.
  always_comb begin
    in_ready = 1'b0;
    if (SKID) begin
      in_ready = (state != ST_TWO);
    end else begin
      in_ready = (state == ST_EMPTY) | out_ready;
    end
  end

  assign in_fire   = in_valid & in_ready;
  assign out_valid = (state != ST_EMPTY);
  assign out_fire  = out_valid & out_ready;
  assign out_data  = main_q;
  assign count     = state;

  // State and payload update; flush wins over every transfer, and a beat
  // presented during flush is dropped while the popped head is still consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_EMPTY;
      main_q <= CLR_VAL;
      skid_q <= CLR_VAL;
    end else if (flush) begin
      state  <= ST_EMPTY;
      main_q <= CLR_VAL;
      skid_q <= CLR_VAL;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            state  <= ST_ONE;
            main_q <= in_data;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (in_fire && SKID) begin
            state  <= ST_TWO;
            skid_q <= in_data;
          end else if (out_fire) begin
            state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            state  <= ST_ONE;
            main_q <= skid_q;
          end
        end
        default: begin
          state <= ST_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance, each with a
// scoreboard queue and a monitor that checks handshake and data every cycle.
module tb_pipe_stage_reg;

  localparam int          W   = 16;
  localparam logic [W-1:0] CLR = 16'hC1C1;

  logic         clk;
  logic         rst_n;

  logic         flush1, in_valid1, in_ready1, out_valid1, out_ready1;
  logic [W-1:0] in_data1, out_data1;
  logic [1:0]   count1;

  logic         flush0, in_valid0, in_ready0, out_valid0, out_ready0;
  logic [W-1:0] in_data0, out_data0;
  logic [1:0]   count0;

  int n_assert = 0;
  int n_fail   = 0;

  logic [W-1:0] q1[$];
  logic [W-1:0] q0[$];
  bit           clr1 = 1'b1;
  bit           clr0 = 1'b1;

  pipe_stage_reg #(.DATA_W(W), .SKID(1'b1), .CLR_VAL(CLR)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .count(count1)
  );

  pipe_stage_reg #(.DATA_W(W), .SKID(1'b0), .CLR_VAL(CLR)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush0),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .count(count0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drv1(input logic v, input logic [W-1:0] d, input logic ordy, input logic fl);
    @(negedge clk);
    in_valid1 = v; in_data1 = d; out_ready1 = ordy; flush1 = fl;
  endtask

  task automatic drv0(input logic v, input logic [W-1:0] d, input logic ordy, input logic fl);
    @(negedge clk);
    in_valid0 = v; in_data0 = d; out_ready0 = ordy; flush0 = fl;
  endtask

  // Monitor for SKID=1: queue size is the model occupancy.
  initial forever begin
    logic rdy;
    @(negedge clk); #4;
    if (!rst_n) begin
      q1.delete(); clr1 = 1'b1;
    end else begin
      rdy = (q1.size() != 2);
      chk("s1_in_ready", in_ready1, rdy);
      chk("s1_out_valid", out_valid1, q1.size() != 0);
      chk("s1_count", count1, q1.size());
      if (q1.size() == 0 && clr1) chk("s1_clr_data", out_data1, CLR);
      if (q1.size() != 0 && out_ready1) begin
        chk("s1_out_data", out_data1, q1[0]);
        void'(q1.pop_front());
      end
      if (flush1) begin
        q1.delete(); clr1 = 1'b1;
      end else if (in_valid1 && rdy) begin
        q1.push_back(in_data1); clr1 = 1'b0;
      end
    end
  end

  // Monitor for SKID=0.
  initial forever begin
    logic rdy;
    @(negedge clk); #4;
    if (!rst_n) begin
      q0.delete(); clr0 = 1'b1;
    end else begin
      rdy = (q0.size() == 0) || out_ready0;
      chk("s0_in_ready", in_ready0, rdy);
      chk("s0_out_valid", out_valid0, q0.size() != 0);
      chk("s0_count", count0, q0.size());
      if (q0.size() == 0 && clr0) chk("s0_clr_data", out_data0, CLR);
      if (q0.size() != 0 && out_ready0) begin
        chk("s0_out_data", out_data0, q0[0]);
        void'(q0.pop_front());
      end
      if (flush0) begin
        q0.delete(); clr0 = 1'b1;
      end else if (in_valid0 && rdy) begin
        q0.push_back(in_data0); clr0 = 1'b0;
      end
    end
  end

  initial begin
    logic [W-1:0] seq;
    rst_n = 1'b0;
    in_valid1 = 1'b1; in_data1 = 16'hAAAA; out_ready1 = 1'b1; flush1 = 1'b0;
    in_valid0 = 1'b1; in_data0 = 16'hAAAA; out_ready0 = 1'b1; flush0 = 1'b0;

    // Reset with upstream offering data.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid1", out_valid1, 1'b0);
    chk("rst_out_data1", out_data1, CLR);
    chk("rst_count1", count1, 2'd0);
    chk("rst_out_valid0", out_valid0, 1'b0);
    chk("rst_out_data0", out_data0, CLR);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid1 = 1'b0; in_valid0 = 1'b0; out_ready1 = 1'b0; out_ready0 = 1'b0;
    #1;
    chk("rel_in_ready1", in_ready1, 1'b1);
    chk("rel_in_ready0", in_ready0, 1'b1);

    // Streaming 1,2,3 with out_ready high.
    drv1(1'b1, 16'd1, 1'b1, 1'b0);
    drv1(1'b1, 16'd2, 1'b1, 1'b0); #4;
    chk("stream_d1", out_data1, 16'd1); chk("stream_c1", count1, 2'd1);
    drv1(1'b1, 16'd3, 1'b1, 1'b0); #4;
    chk("stream_d2", out_data1, 16'd2); chk("stream_c2", count1, 2'd1);
    drv1(1'b0, 16'd0, 1'b1, 1'b0); #4;
    chk("stream_d3", out_data1, 16'd3); chk("stream_c3", count1, 2'd1);
    drv1(1'b0, 16'd0, 1'b1, 1'b0); #4;
    chk("stream_empty", out_valid1, 1'b0);

    // Back-pressure: 5, 6 held, then drained in order.
    drv1(1'b1, 16'd5, 1'b0, 1'b0);
    drv1(1'b1, 16'd6, 1'b0, 1'b0); #4;
    chk("bp_c1", count1, 2'd1); chk("bp_d1", out_data1, 16'd5);
    drv1(1'b0, 16'd0, 1'b0, 1'b0); #4;
    chk("bp_c2", count1, 2'd2); chk("bp_rdy2", in_ready1, 1'b0);
    chk("bp_stall_d", out_data1, 16'd5);
    drv1(1'b0, 16'd0, 1'b1, 1'b0); #4;
    chk("bp_pop_d5", out_data1, 16'd5); chk("bp_rdy_full", in_ready1, 1'b0);
    drv1(1'b0, 16'd0, 1'b1, 1'b0); #4;
    chk("bp_pop_d6", out_data1, 16'd6); chk("bp_rdy_after", in_ready1, 1'b1);
    drv1(1'b0, 16'd0, 1'b0, 1'b0); #4;
    chk("bp_empty", count1, 2'd0);

    // Flush while TWO holds 7,8 with 9 offered.
    drv1(1'b1, 16'd7, 1'b0, 1'b0);
    drv1(1'b1, 16'd8, 1'b0, 1'b0);
    drv1(1'b1, 16'd9, 1'b0, 1'b1); #4;
    chk("fl_two", count1, 2'd2);
    drv1(1'b0, 16'd0, 1'b1, 1'b0); #4;
    chk("fl_count", count1, 2'd0); chk("fl_valid", out_valid1, 1'b0);
    chk("fl_data", out_data1, CLR);
    // Flush from ONE while a new beat is accepted: that beat is discarded.
    drv1(1'b1, 16'd10, 1'b0, 1'b0);
    drv1(1'b1, 16'd11, 1'b0, 1'b1); #4;
    chk("fl1_rdy", in_ready1, 1'b1);
    drv1(1'b0, 16'd0, 1'b1, 1'b0); #4;
    chk("fl1_count", count1, 2'd0); chk("fl1_data", out_data1, CLR);
    drv1(1'b0, 16'd0, 1'b0, 1'b0);

    // SKID=0: ready follows out_ready when full.
    drv0(1'b1, 16'd4, 1'b0, 1'b0);
    drv0(1'b0, 16'd0, 1'b0, 1'b0); #4;
    chk("s0_held", out_data0, 16'd4); chk("s0_rdy_stall", in_ready0, 1'b0);
    drv0(1'b1, 16'd5, 1'b1, 1'b0); #1;
    chk("s0_rdy_pass", in_ready0, 1'b1);
    drv0(1'b0, 16'd0, 1'b0, 1'b0); #4;
    chk("s0_next", out_data0, 16'd5); chk("s0_cnt", count0, 2'd1);
    drv0(1'b0, 16'd0, 1'b1, 1'b0);
    drv0(1'b0, 16'd0, 1'b0, 1'b0); #4;
    chk("s0_empty", count0, 2'd0);

    // Reset asserted mid-transfer drops everything.
    drv1(1'b1, 16'h55, 1'b0, 1'b0);
    drv1(1'b1, 16'h66, 1'b0, 1'b0);
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    chk("mrst_count", count1, 2'd0); chk("mrst_valid", out_valid1, 1'b0);
    chk("mrst_data", out_data1, CLR); chk("mrst_rdy", in_ready1, 1'b1);
    @(negedge clk);
    in_valid1 = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b1;

    // Random traffic on both instances with unique payloads.
    seq = 16'h0100;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      in_valid1 = ($urandom % 4) != 0; out_ready1 = ($urandom % 3) != 0;
      flush1 = ($urandom % 50) == 0; in_data1 = seq; seq++;
      in_valid0 = ($urandom % 4) != 0; out_ready0 = ($urandom % 3) != 0;
      flush0 = ($urandom % 50) == 0; in_data0 = seq; seq++;
    end
    @(negedge clk);
    in_valid1 = 1'b0; out_ready1 = 1'b1; flush1 = 1'b0;
    in_valid0 = 1'b0; out_ready0 = 1'b1; flush0 = 1'b0;
    repeat (4) @(negedge clk);
    #4;
    chk("drain_q1", q1.size(), 0);
    chk("drain_q0", q0.size(), 0);
    chk("drain_cnt1", count1, 2'd0);
    chk("drain_cnt0", count0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
